// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg: shared channel state encoding and counter sizing helper
package key_conditioner_pkg;

    // Bit 1 of the state is the debounced level; bit 0 marks a pending change.
    typedef enum logic [1:0] {
        RELEASED   = 2'b00,
        CONF_PRESS = 2'b01,
        HELD       = 2'b10,
        CONF_REL   = 2'b11
    } key_state_e;

    // Width able to hold the values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// key_conditioner_channel: synchroniser, debounce FSM and auto-repeat for one key
module key_conditioner_channel
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int DEB_W = cnt_w(DEBOUNCE_CYCLES);
    localparam int REP_W = cnt_w((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic             s1_q, s2_q;
    key_state_e       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             first_q, first_d;
    logic             press_q, release_q, repeat_q;
    logic             level, diff, accept, rep_fire;

    assign level    = state_q[1];
    assign diff     = s2_q != level;
    assign accept   = diff && (deb_cnt_q == DEB_LAST);
    assign rep_fire = (state_q == HELD) && (rep_cnt_q == (first_q ? REP_LAST : HOLD_LAST));

    // Next state: debounce count, confirm/accept transitions, repeat timing
    always_comb begin
        deb_cnt_d = (diff && !accept) ? deb_cnt_q + 1'b1 : '0;
        state_d   = accept ? (s2_q ? HELD : RELEASED)
                  : diff   ? (level ? CONF_REL : CONF_PRESS)
                  :          (level ? HELD : RELEASED);
        rep_cnt_d = (accept && s2_q) ? '0
                  : rep_fire         ? '0
                  : (state_q == HELD) ? rep_cnt_q + 1'b1
                  :                    rep_cnt_q;
        first_d   = (accept && s2_q) ? 1'b0 : (rep_fire ? 1'b1 : first_q);
    end

    // Channel registers; all outputs come straight from flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= RELEASED;
            deb_cnt_q <= '0;
            rep_cnt_q <= '0;
            first_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            s1_q      <= ~key_i;
            s2_q      <= s1_q;
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            first_q   <= first_d;
            press_q   <= accept && s2_q;
            release_q <= accept && !s2_q;
            repeat_q  <= REPEAT_EN && rep_fire;
        end
    end

    assign level_o   = state_q[1];
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounced level and press/release/repeat pulses for active-low keys
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic                clk100_i,
    input  logic                rst_i,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic [NUM_KEYS-1:0] key_level_o,
    output logic [NUM_KEYS-1:0] key_press_o,
    output logic [NUM_KEYS-1:0] key_release_o,
    output logic [NUM_KEYS-1:0] key_repeat_o
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_conditioner_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .REPEAT_EN      (REPEAT_EN)
        ) u_ch (
            .clk_i    (clk100_i),
            .rst_i    (rst_i),
            .key_i    (key_i[g]),
            .level_o  (key_level_o[g]),
            .press_o  (key_press_o[g]),
            .release_o(key_release_o[g]),
            .repeat_o (key_repeat_o[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce latency, bounce, glitch, repeat and reset
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key = 2'b11;
    logic [1:0] level, press, rel, rep;
    logic [1:0] p_press = '0, p_rel = '0, p_rep = '0;
    int         n_chk = 0;
    int         n_fail = 0;

    key_conditioner #(
        .NUM_KEYS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b1)
    ) dut (
        .clk100_i     (clk),
        .rst_i        (rst),
        .key_i        (key),
        .key_level_o  (level),
        .key_press_o  (press),
        .key_release_o(rel),
        .key_repeat_o (rep)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pulses must be one cycle wide and press/release never overlap on a bit
    always @(negedge clk) begin
        chk("pulse_rules", (press & rel) | (press & p_press) | (rel & p_rel) | (rep & p_rep), 2'b00);
        p_press <= press;
        p_rel   <= rel;
        p_rep   <= rep;
    end

    initial begin
        step(); step(); step();
        chk("rst_level", level, 2'b00);
        chk("rst_press", press, 2'b00);
        chk("rst_release", rel, 2'b00);
        chk("rst_repeat", rep, 2'b00);
        rst = 1'b0;
        step(); step(); step();
        chk("idle_level", level, 2'b00);
        // clean press on key 0, then hold for auto-repeat and release
        key = 2'b10;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("t1_press", press, (i == 6) ? 2'b01 : 2'b00);
            if (i == 5) chk("t1_level_before", level, 2'b00);
            if (i == 6) chk("t1_level_after", level, 2'b01);
        end
        for (int i = 2; i <= 40; i++) begin
            step();
            chk("t4_repeat", rep, (i >= 10 && i <= 28 && (i - 10) % 3 == 0) ? 2'b01 : 2'b00);
            chk("t1_release", rel, (i == 32) ? 2'b01 : 2'b00);
            chk("t1_no_press", press, 2'b00);
            if (i == 26) key = 2'b11;
        end
        chk("t1_level_final", level, 2'b00);
        // bounce: low 3, high 1, then low steady
        key = 2'b10;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t2_bounce_press", press, 2'b00);
        end
        key = 2'b11;
        step();
        chk("t2_bounce_press", press, 2'b00);
        key = 2'b10;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t2_press", press, (i == 6) ? 2'b01 : 2'b00);
            chk("t2_no_release", rel, 2'b00);
        end
        key = 2'b11;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t2_release", rel, (i == 6) ? 2'b01 : 2'b00);
        end
        chk("t2_level", level, 2'b00);
        // glitch on key 1 shorter than the debounce window
        key = 2'b01;
        step(); step();
        key = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("t3_press", press, 2'b00);
            chk("t3_release", rel, 2'b00);
            chk("t3_level", level, 2'b00);
        end
        // both keys fall together, then only key 1 released
        key = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t5_press", press, (i == 6) ? 2'b11 : 2'b00);
        end
        chk("t5_level", level, 2'b11);
        key = 2'b10;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t5_release", rel, (i == 6) ? 2'b10 : 2'b00);
        end
        chk("t5_level_k0", level, 2'b01);
        // reset while key 0 held
        rst = 1'b1;
        #1;
        chk("t6_rst_level", level, 2'b00);
        chk("t6_rst_press", press, 2'b00);
        chk("t6_rst_release", rel, 2'b00);
        chk("t6_rst_repeat", rep, 2'b00);
        step(); step();
        chk("t6_rst_held_release", rel, 2'b00);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("t6_press", press, (i == 6) ? 2'b01 : 2'b00);
            chk("t6_no_release", rel, 2'b00);
            if (i == 6) chk("t6_level", level, 2'b01);
        end
        key = 2'b11;
        for (int i = 1; i <= 8; i++) step();
        chk("end_level", level, 2'b00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
